// File: rtl/cu_pkg.sv
// cu_pkg: shared encodings for the pipelined control unit (ops, condition codes,
// ALU control constants, flag bit positions, stage control bundles).
package cu_pkg;
  typedef enum logic [1:0] {
    OP_DP   = 2'b00,
    OP_MEM  = 2'b01,
    OP_BR   = 2'b10,
    OP_NONE = 2'b11
  } op_e;
  typedef enum logic [3:0] {
    C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_e;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam int FN = 3;
  localparam int FZ = 2;
  localparam int FC = 1;
  localparam int FV = 0;
  typedef struct packed {
    logic       reg_w;
    logic       mem_w;
    logic       mem2reg;
    logic       branch;
    logic       pcs;
    logic [1:0] flag_w;
  } ctrl_t;
  typedef struct packed {
    logic reg_w;
    logic mem2reg;
    logic pcs;
  } wb_t;
endpackage

// File: rtl/cu_cond_check.sv
// cu_cond_check: combinational ARM condition-code evaluation against {N,Z,C,V}.
module cu_cond_check
  import cu_pkg::*;
#(
  parameter int FLAG_W = 4
) (
  input  logic [3:0]        cond,
  input  logic [FLAG_W-1:0] flags,
  output logic              condEx
);
  logic n, z, c, v;
  assign n = flags[FN];
  assign z = flags[FZ];
  assign c = flags[FC];
  assign v = flags[FV];
  always_comb begin
    condEx = 1'b0;
    case (cond_e'(cond))
      C_EQ:    condEx = z;
      C_NE:    condEx = ~z;
      C_CS:    condEx = c;
      C_CC:    condEx = ~c;
      C_MI:    condEx = n;
      C_PL:    condEx = ~n;
      C_VS:    condEx = v;
      C_VC:    condEx = ~v;
      C_HI:    condEx = c & ~z;
      C_LS:    condEx = ~c | z;
      C_GE:    condEx = n == v;
      C_LT:    condEx = n != v;
      C_GT:    condEx = ~z & (n == v);
      C_LE:    condEx = z | (n != v);
      C_AL:    condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end
endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: D-stage decode with E/M/W control pipeline and flag register.
// Optional retired/squashed counters are built when CU_PERF_CNT_EN is defined.
module pipe_control_unit
  import cu_pkg::*;
#(
  parameter int ALUCTL_W = 4,
  parameter int FLAG_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          opD,
  input  logic [3:0]          cmdD,
  input  logic [1:0]          indD,
  input  logic [3:0]          condD,
  input  logic [3:0]          rdD,
  input  logic                flushE,
  input  logic [FLAG_W-1:0]   aluFlagsE,
  output logic [1:0]          immSrcD,
  output logic [1:0]          regSrcD,
  output logic [ALUCTL_W-1:0] aluControlE,
  output logic                aluSrcE,
  output logic                branchTakenE,
  output logic                memWriteM,
  output logic                regWriteW,
  output logic                memtoRegW,
  output logic                pcSrcW,
  output logic [FLAG_W-1:0]   flagsQ
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]         retiredQ,
  output logic [31:0]         squashedQ
`endif
);
  ctrl_t               dec, e_d, e_q;
  logic [ALUCTL_W-1:0] alu_ctl_d, alu_ctl_q;
  logic                alu_src_d, alu_src_q;
  logic [3:0]          cond_q;
  logic                cond_ex;
  logic                mem_w_m_d, mem_w_m_q;
  wb_t                 wb_m_d, wb_m_q, wb_w_q;
  logic [FLAG_W-1:0]   flags_d, flags_q;
  always_comb begin
    dec       = '0;
    immSrcD   = 2'b00;
    alu_src_d = 1'b0;
    alu_ctl_d = '0;
    case (op_e'(opD))
      OP_DP: begin
        alu_ctl_d  = ALUCTL_W'(cmdD);
        alu_src_d  = indD[1];
        dec.reg_w  = cmdD != ALU_CMP;
        dec.flag_w = (indD[0] | (cmdD == ALU_CMP)) ?
                     ((cmdD == ALU_ADD || cmdD == ALU_SUB || cmdD == ALU_CMP) ? 2'b11 : 2'b10) : 2'b00;
      end
      OP_MEM: begin
        immSrcD     = 2'b01;
        alu_src_d   = 1'b1;
        alu_ctl_d   = ALUCTL_W'(ALU_ADD);
        dec.mem_w   = ~indD[0];
        dec.reg_w   = indD[0];
        dec.mem2reg = indD[0];
      end
      OP_BR: begin
        immSrcD    = 2'b10;
        alu_src_d  = 1'b1;
        alu_ctl_d  = ALUCTL_W'(ALU_ADD);
        dec.branch = 1'b1;
      end
      default: ;
    endcase
    dec.pcs = dec.branch | (dec.reg_w & (rdD == 4'hF));
    e_d     = flushE ? '0 : dec;
  end
  assign regSrcD = {opD == OP_MEM, opD == OP_BR};
  cu_cond_check #(.FLAG_W(FLAG_W)) u_cond (
    .cond   (cond_q),
    .flags  (flags_q),
    .condEx (cond_ex)
  );
  // Flags written here are visible to the very next E-stage instruction.
  always_comb begin
    mem_w_m_d      = e_q.mem_w & cond_ex;
    wb_m_d.reg_w   = e_q.reg_w & cond_ex;
    wb_m_d.mem2reg = e_q.mem2reg & cond_ex;
    wb_m_d.pcs     = e_q.pcs & cond_ex;
    flags_d        = flags_q;
    if (e_q.flag_w[1] & cond_ex) {flags_d[FN], flags_d[FZ]} = {aluFlagsE[FN], aluFlagsE[FZ]};
    if (e_q.flag_w[0] & cond_ex) {flags_d[FC], flags_d[FV]} = {aluFlagsE[FC], aluFlagsE[FV]};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      e_q       <= '0;
      alu_ctl_q <= '0;
      alu_src_q <= 1'b0;
      cond_q    <= '0;
      mem_w_m_q <= 1'b0;
      wb_m_q    <= '0;
      wb_w_q    <= '0;
      flags_q   <= '0;
    end else begin
      e_q       <= e_d;
      alu_ctl_q <= alu_ctl_d;
      alu_src_q <= alu_src_d;
      cond_q    <= condD;
      mem_w_m_q <= mem_w_m_d;
      wb_m_q    <= wb_m_d;
      wb_w_q    <= wb_m_q;
      flags_q   <= flags_d;
    end
  end
  assign aluControlE  = alu_ctl_q;
  assign aluSrcE      = alu_src_q;
  assign branchTakenE = e_q.branch & cond_ex;
  assign memWriteM    = mem_w_m_q;
  assign regWriteW    = wb_w_q.reg_w;
  assign memtoRegW    = wb_w_q.mem2reg;
  assign pcSrcW       = wb_w_q.pcs;
  assign flagsQ       = flags_q;
`ifdef CU_PERF_CNT_EN
  logic        valid_e_d, valid_e_q, valid_m_q, valid_w_q;
  logic [31:0] retired_d, retired_q, squashed_d, squashed_q;
  always_comb begin
    valid_e_d  = ~flushE;
    retired_d  = retired_q + {31'b0, valid_w_q};
    squashed_d = squashed_q + {31'b0, valid_e_q & ~cond_ex};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_e_q  <= 1'b0;
      valid_m_q  <= 1'b0;
      valid_w_q  <= 1'b0;
      retired_q  <= '0;
      squashed_q <= '0;
    end else begin
      valid_e_q  <= valid_e_d;
      valid_m_q  <= valid_e_q;
      valid_w_q  <= valid_m_q;
      retired_q  <= retired_d;
      squashed_q <= squashed_d;
    end
  end
  assign retiredQ  = retired_q;
  assign squashedQ = squashed_q;
`endif
endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit: scoreboard bench; an in-order ISA-level model predicts each
// stage's outputs, a negedge monitor pops and compares them.
module tb_pipe_control_unit;
  logic       clk = 1'b1;
  logic       rst = 1'b0;
  logic [1:0] opD = '0, indD = '0;
  logic [3:0] cmdD = '0, condD = '0, rdD = '0;
  logic       flushE = 1'b0;
  logic [3:0] aluFlagsE = '0;
  logic [1:0] immSrcD, regSrcD;
  logic [3:0] aluControlE, flagsQ;
  logic       aluSrcE, branchTakenE, memWriteM, regWriteW, memtoRegW, pcSrcW;
`ifdef CU_PERF_CNT_EN
  logic [31:0] retiredQ, squashedQ;
`endif

  pipe_control_unit #(.ALUCTL_W(4), .FLAG_W(4)) dut (
    .clk(clk), .rst(rst), .opD(opD), .cmdD(cmdD), .indD(indD), .condD(condD), .rdD(rdD),
    .flushE(flushE), .aluFlagsE(aluFlagsE), .immSrcD(immSrcD), .regSrcD(regSrcD),
    .aluControlE(aluControlE), .aluSrcE(aluSrcE), .branchTakenE(branchTakenE),
    .memWriteM(memWriteM), .regWriteW(regWriteW), .memtoRegW(memtoRegW), .pcSrcW(pcSrcW),
    .flagsQ(flagsQ)
`ifdef CU_PERF_CNT_EN
    , .retiredQ(retiredQ), .squashedQ(squashedQ)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [1:0] imm; logic [1:0] rsrc; bit chk;} d_t;
  typedef struct {int due; bit chk; logic [3:0] alu; logic src; logic bt;} e_t;
  typedef struct {int due; logic mw; logic [3:0] fl; int unsigned sq;} m_t;
  typedef struct {int due; logic rw; logic m2r; logic pcs;} w_t;
  d_t qd[$];
  e_t qe[$];
  m_t qm[$];
  w_t qw[$];
  d_t d;
  e_t e;
  m_t m;
  w_t w;

  int          cyc = 0, checks = 0, errors = 0;
  logic [3:0]  mflags = '0, prev_af = '0;
  int unsigned msq = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic [3:0] cmd, input logic [1:0] ind,
                       input logic [3:0] cond, input logic [3:0] rd, input logic fl,
                       input logic [3:0] af, input logic rn);
    int n;
    logic [3:0] alu;
    logic [1:0] imm;
    logic src, rw, mw, m2r, br, nz, cv, pcs, pass;
    n = cyc + 1;
    opD = op; cmdD = cmd; indD = ind; condD = cond; rdD = rd; flushE = fl; rst = rn;
    aluFlagsE = prev_af;
    prev_af = af;
    alu = 4'h0; imm = 2'b00; src = 0; rw = 0; mw = 0; m2r = 0; br = 0; nz = 0; cv = 0;
    if (op == 2'd0) begin
      alu = cmd; src = ind[1]; rw = (cmd != 4'hA);
      nz = ind[0] || cmd == 4'hA;
      cv = nz && (cmd == 4'h4 || cmd == 4'h2 || cmd == 4'hA);
    end else if (op == 2'd1) begin
      alu = 4'h4; src = 1; imm = 2'b01; mw = !ind[0]; rw = ind[0]; m2r = ind[0];
    end else if (op == 2'd2) begin
      alu = 4'h4; src = 1; imm = 2'b10; br = 1;
    end
    pcs = br || (rw && rd == 4'hF);
    qd.push_back('{n - 1, imm, {op == 2'd1, op == 2'd2}, op != 2'd3});
    if (!rn) begin
      foreach (qm[i]) if (qm[i].due >= n) begin qm[i].mw = 0; qm[i].fl = 0; qm[i].sq = 0; end
      foreach (qw[i]) if (qw[i].due >= n) begin qw[i].rw = 0; qw[i].m2r = 0; qw[i].pcs = 0; end
      mflags = '0;
      msq = 0;
      qe.push_back('{n, 1'b1, 4'h0, 1'b0, 1'b0});
      qm.push_back('{n + 1, 1'b0, 4'h0, 0});
      qw.push_back('{n + 2, 1'b0, 1'b0, 1'b0});
    end else begin
      pass = !fl && cond_ok(cond, mflags);
      qe.push_back('{n, op != 2'd3, alu, src, br && pass});
      if (pass && nz) mflags[3:2] = af[3:2];
      if (pass && cv) mflags[1:0] = af[1:0];
      if (!fl && !pass) msq++;
      qm.push_back('{n + 1, mw && pass, mflags, msq});
      qw.push_back('{n + 2, rw && pass, m2r && pass, pcs && pass});
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (qd.size() > 0 && qd[0].due <= cyc) begin
      d = qd.pop_front();
      if (d.due < cyc) chk("d_late", 32'(d.due), 32'(cyc));
      else begin
        if (d.chk) chk("immSrcD", 32'(immSrcD), 32'(d.imm));
        chk("regSrcD", 32'(regSrcD), 32'(d.rsrc));
      end
    end
    while (qe.size() > 0 && qe[0].due <= cyc) begin
      e = qe.pop_front();
      if (e.due < cyc) chk("e_late", 32'(e.due), 32'(cyc));
      else begin
        if (e.chk) chk("aluControlE", 32'(aluControlE), 32'(e.alu));
        if (e.chk) chk("aluSrcE", 32'(aluSrcE), 32'(e.src));
        chk("branchTakenE", 32'(branchTakenE), 32'(e.bt));
      end
    end
    while (qm.size() > 0 && qm[0].due <= cyc) begin
      m = qm.pop_front();
      if (m.due < cyc) chk("m_late", 32'(m.due), 32'(cyc));
      else begin
        chk("memWriteM", 32'(memWriteM), 32'(m.mw));
        chk("flagsQ", 32'(flagsQ), 32'(m.fl));
`ifdef CU_PERF_CNT_EN
        chk("squashedQ", squashedQ, m.sq);
`endif
      end
    end
    while (qw.size() > 0 && qw[0].due <= cyc) begin
      w = qw.pop_front();
      if (w.due < cyc) chk("w_late", 32'(w.due), 32'(cyc));
      else begin
        chk("regWriteW", 32'(regWriteW), 32'(w.rw));
        chk("memtoRegW", 32'(memtoRegW), 32'(w.m2r));
        chk("pcSrcW", 32'(pcSrcW), 32'(w.pcs));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    issue(2'd0, 4'h4, 2'b00, 4'hE, 4'd1, 1'b0, 4'h0, 1'b0);
    issue(2'd0, 4'h4, 2'b00, 4'hE, 4'd1, 1'b0, 4'h0, 1'b0);
    issue(2'd0, 4'h2, 2'b01, 4'hE, 4'd1, 1'b0, 4'b0100, 1'b1);
    issue(2'd2, 4'h0, 2'b00, 4'h0, 4'd0, 1'b0, 4'h0, 1'b1);
    issue(2'd0, 4'h4, 2'b00, 4'h1, 4'd2, 1'b0, 4'h0, 1'b1);
    issue(2'd1, 4'h0, 2'b00, 4'hE, 4'd3, 1'b1, 4'h0, 1'b1);
    issue(2'd0, 4'h2, 2'b01, 4'hE, 4'd1, 1'b0, 4'h0, 1'b1);
    issue(2'd0, 4'h0, 2'b01, 4'hE, 4'd1, 1'b0, 4'b1011, 1'b1);
    issue(2'd0, 4'hD, 2'b10, 4'hE, 4'hF, 1'b0, 4'h0, 1'b1);
    issue(2'd0, 4'h4, 2'b01, 4'hF, 4'hF, 1'b0, 4'hF, 1'b1);
    issue(2'd1, 4'h0, 2'b01, 4'hE, 4'd3, 1'b0, 4'h0, 1'b1);
    issue(2'd1, 4'h0, 2'b00, 4'hE, 4'd4, 1'b0, 4'h0, 1'b1);
    issue(2'd0, 4'h4, 2'b01, 4'hE, 4'hF, 1'b0, 4'hF, 1'b1);
    issue(2'd0, 4'h4, 2'b01, 4'hE, 4'hF, 1'b0, 4'hF, 1'b0);
    issue(2'd1, 4'h0, 2'b01, 4'hE, 4'd3, 1'b0, 4'h0, 1'b1);
    repeat (800) begin
      issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE,
            4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 49) != 0);
    end
    repeat (3) issue(2'd3, 4'h0, 2'b00, 4'hE, 4'd0, 1'b0, 4'h0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("drained", 32'(qd.size() + qe.size() + qm.size() + qw.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
